instr_mem_server: RTL

//  Instruction store on the responder side of the processor fetch interface: it returns a 16-bit instruction for each 4-bit fetch address.
//  It also holds a byte-serial program loader that writes the store at run time, hi byte first.

---
 rtl/instr_mem_pkg.sv | 34 +++
 rtl/instr_mem_server_loader.sv | 115 +++++++++++
 rtl/instr_mem_server.sv | 92 +++++++++
 3 files changed

// File: rtl/instr_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_pkg
// Purpose  : Shared constants and types for the instruction store and its
//            byte-serial program loader: loader state encoding, instruction
//            width, NOP word and opcode constants shared with the processor.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package instr_mem_pkg;

  // Instruction width is fixed: the loader pairs exactly two bytes per word.
  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] NOP_WORD = 16'h0000;

  // Opcode field (instruction bits [15:12]) shared with the processor decoder.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_OUT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_DONE = 2'd3
  } ld_state_t;

endpackage : instr_mem_pkg
`default_nettype wire

// File: rtl/instr_mem_server_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader
// Purpose  : Byte-serial program loader. Collects hi/lo byte pairs and emits
//            one write strobe per completed word, starting at word 0.
//            Optional checksum output when IMEM_CHECKSUM_EN is defined.
// Ports    : clk, rst_n          clock, async active-low reset
//            ld_start            pulse, begin load at word 0 (IDLE only)
//            ld_byte/ld_valid    byte stream, taken when ld_valid&&ld_ready
//            ld_last             with lo byte: final word
//            ld_ready/ld_busy    handshake / load-in-progress status
//            ld_done             one-cycle completion pulse
//            ld_count            words written by last/current load
//            ld_csum             (IMEM_CHECKSUM_EN) sum of written words
//            wr_en/addr/data     write port toward the memory array
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic [7:0]        ld_byte,
  input  logic              ld_valid,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_count,
`ifdef IMEM_CHECKSUM_EN
  output logic [DATA_W-1:0] ld_csum,
`endif
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam logic [ADDR_W-1:0] LAST_PTR = '1;

  ld_state_t         state;
  ld_state_t         state_nx;
  logic [7:0]        hi_reg;
  logic [ADDR_W-1:0] ptr;
  logic              start_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    wr_en     = 1'b0;
    start_acc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ld_start) begin
          start_acc = 1'b1;
          state_nx  = ST_HI;
        end
      end
      ST_HI: begin
        if (ld_valid) state_nx = ST_LO;
      end
      ST_LO: begin
        if (ld_valid) begin
          wr_en = 1'b1;
          // The last word slot ends the load even without ld_last, so the
          // pointer never wraps back onto word 0.
          if (ld_last || (ptr == LAST_PTR)) state_nx = ST_DONE;
          else                              state_nx = ST_HI;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign ld_ready = (state == ST_HI) || (state == ST_LO);
  assign ld_busy  = (state != ST_IDLE);
  assign ld_done  = (state == ST_DONE);
  assign wr_addr  = ptr;
  assign wr_data  = {hi_reg, ld_byte};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_reg   <= 8'h00;
      ptr      <= '0;
      ld_count <= '0;
    end else begin
      if ((state == ST_HI) && ld_valid) hi_reg <= ld_byte;

      if (start_acc) begin
        ptr      <= '0;
        ld_count <= '0;
      end else if (wr_en) begin
        ld_count <= ld_count + 1'b1;
        if (state_nx == ST_HI) ptr <= ptr + 1'b1;
      end
    end
  end

`ifdef IMEM_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ld_csum <= '0;
    else if (start_acc) ld_csum <= '0;
    else if (wr_en)     ld_csum <= ld_csum + wr_data;
  end
`endif

endmodule : instr_mem_loader
`default_nettype wire

// File: rtl/instr_mem_server.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_server
// Purpose  : Run-time loadable instruction store for the processor fetch
//            port. Holds the memory array and the one-cycle registered read
//            port; writes come from the byte-serial loader sub-module.
//            Define IMEM_CHECKSUM_EN to add the ld_csum output.
// Ports    : clk, rst_n                    clock, async active-low reset
//            rd_req/rd_addr/rd_ready       fetch request handshake
//            rd_valid/rd_data              fetch response (latency 1)
//            ld_start/ld_byte/ld_valid/    loader input stream
//            ld_last
//            ld_ready/ld_busy/ld_done/     loader status
//            ld_count
//            ld_csum                       (IMEM_CHECKSUM_EN) word checksum
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_server
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              ld_start,
  input  logic [7:0]        ld_byte,
  input  logic              ld_valid,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
`ifdef IMEM_CHECKSUM_EN
  output logic [DATA_W-1:0] ld_csum,
`endif
  output logic [ADDR_W:0]   ld_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_acc;

  instr_mem_loader #(
    .ADDR_W (ADDR_W)
  ) u_loader (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_start (ld_start),
    .ld_byte  (ld_byte),
    .ld_valid (ld_valid),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .ld_busy  (ld_busy),
    .ld_done  (ld_done),
    .ld_count (ld_count),
`ifdef IMEM_CHECKSUM_EN
    .ld_csum  (ld_csum),
`endif
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  // Contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Fetches are locked out for the whole load, so a read never races a write.
  assign rd_ready = !ld_busy;
  assign rd_acc   = rd_req && rd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= NOP_WORD;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= mem[rd_addr];
    end
  end

endmodule : instr_mem_server
`default_nettype wire
